// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Byte-stream handshake carrying a program image into the instruction
//   memory loader. A byte moves when in_valid and in_ready are both high at
//   a rising clock edge.
//
//   in_valid  source -> loader  in_data holds a byte
//   in_data   source -> loader  stream byte, held stable until accepted
//   in_ready  loader -> source  loader accepts the byte this cycle
//
//   master : the byte source
//   slave  : the loader
// ---------------------------------------------------------------------------
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the processor's instruction memory. Takes a program as a
//   byte stream (header N, 4*N payload bytes MSB first, XOR checksum byte),
//   packs the payload into 32-bit big-endian words with one imem write per
//   word, verifies the checksum and keeps the processor PC cleared until the
//   load has completed successfully.
//
//   Parameters
//     ADDR_W      imem word-address width (capacity 2**ADDR_W words)
//     BASE_ADDR   imem word address of the first loaded word
//
//   Ports
//     clk         system clock, rising edge
//     clr_n       asynchronous active-low reset
//     in_if       byte-stream handshake (slave side)
//     imem_we     imem write strobe, high only in the WRITE cycle
//     imem_addr   imem write word address (holds last value)
//     imem_wdata  imem write word (holds last value)
//     cpu_hold    1 = keep processor PC cleared
//     done        load complete with good checksum (sticky)
//     err         load aborted (sticky)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    imem_loader_if.slave      in_if,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned        CAP    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  BASE_A = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_HDR     = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_CSUM    = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t            state_q;
    logic [7:0]        n_q;
    logic [7:0]        word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        csum_q;
    logic [31:0]       shift_q;
    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              hdr_bad;
    logic              last_word;
    logic [31:0]       shift_d;
    logic [7:0]        csum_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        accept    = in_if.in_valid & in_ready_q;
        // Header must name between 1 and CAP words; compare at 32 bits so a
        // capacity above 255 words never truncates.
        hdr_bad   = (in_if.in_data == 8'd0) || (32'(in_if.in_data) > CAP);
        last_word = (word_idx_q == (n_q - 8'd1));
        shift_d   = {shift_q[23:0], in_if.in_data};
        csum_d    = csum_q ^ in_if.in_data;
        // Address arithmetic is ADDR_W bits wide, so it wraps naturally.
        addr_d    = BASE_A + ADDR_W'(word_idx_q);
    end

    // All outputs are registered and are loaded on the transition into the
    // state that owns them, so they are valid for the whole of that state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= S_HDR;
            n_q          <= 8'd0;
            word_idx_q   <= 8'd0;
            byte_idx_q   <= 2'd0;
            csum_q       <= 8'd0;
            shift_q      <= 32'd0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            n_q        <= in_if.in_data;
                            csum_q     <= in_if.in_data;
                            byte_idx_q <= 2'd0;
                            word_idx_q <= 8'd0;
                            state_q    <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        shift_q    <= shift_d;
                        csum_q     <= csum_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q      <= S_WRITE;
                            in_ready_q   <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= addr_d;
                            imem_wdata_q <= shift_d;
                        end
                    end
                end
                S_WRITE: begin
                    imem_we_q  <= 1'b0;
                    in_ready_q <= 1'b1;
                    word_idx_q <= word_idx_q + 8'd1;
                    byte_idx_q <= 2'd0;
                    state_q    <= last_word ? S_CSUM : S_COLLECT;
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_if.in_data == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    // Terminal until reset.
                end
                default: begin
                    state_q <= S_HDR;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign imem_we        = imem_we_q;
    assign imem_addr      = imem_addr_q;
    assign imem_wdata     = imem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Two instances see the same byte stream:
//   one at BASE_ADDR 0 and one at BASE_ADDR 62 (address wrap).
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic clk;
    logic clr_n;

    imem_loader_if sif0 ();
    imem_loader_if sif1 ();

    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [31:0]       wdata0, wdata1;
    logic              hold0, hold1;
    logic              done0, done1;
    logic              err0, err1;

    // Shared stimulus drives both instances.
    logic       st_valid;
    logic [7:0] st_data;

    assign sif0.in_valid = st_valid;
    assign sif0.in_data  = st_data;
    assign sif1.in_valid = st_valid;
    assign sif1.in_data  = st_data;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut0 (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_if      (sif0.slave),
        .imem_we    (we0),
        .imem_addr  (addr0),
        .imem_wdata (wdata0),
        .cpu_hold   (hold0),
        .done       (done0),
        .err        (err0)
    );

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(62)) dut1 (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_if      (sif1.slave),
        .imem_we    (we1),
        .imem_addr  (addr1),
        .imem_wdata (wdata1),
        .cpu_hold   (hold1),
        .done       (done1),
        .err        (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wa0[$];
    logic [31:0]       wd0[$];
    logic [ADDR_W-1:0] wa1[$];
    int                rdy_in_write = 0;

    // Capture every imem write; also flag in_ready asserted during a write.
    always @(negedge clk) begin
        if (we0) begin
            wa0.push_back(addr0);
            wd0.push_back(wdata0);
            if (sif0.in_ready) rdy_in_write++;
        end
        if (we1) wa1.push_back(addr1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa0.delete();
        wd0.delete();
        wa1.delete();
        rdy_in_write = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(sif0.in_ready), 32'd1);
        chk({tag, "_we"},    32'(we0),           32'd0);
        chk({tag, "_addr"},  32'(addr0),         32'd0);
        chk({tag, "_wdata"}, wdata0,             32'd0);
        chk({tag, "_hold"},  32'(hold0),         32'd1);
        chk({tag, "_done"},  32'(done0),         32'd0);
        chk({tag, "_err"},   32'(err0),          32'd0);
    endtask

    // Assert reset asynchronously mid-cycle, check outputs while it is low.
    task automatic do_reset(input string tag);
        st_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check_reset_vals(tag);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        clear_log();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int gap;
        logic acc;
        gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        st_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        st_valid = 1'b1;
        st_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = sif0.in_ready;
            @(posedge clk);
            #1;
        end
        st_valid = 1'b0;
        chk("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        send_byte(w[31:24], gapmax);
        send_byte(w[23:16], gapmax);
        send_byte(w[15:8],  gapmax);
        send_byte(w[7:0],   gapmax);
    endtask

    initial begin
        st_valid = 1'b0;
        st_data  = 8'h00;
        clr_n    = 1'b1;
        @(posedge clk);
        #1;
        do_reset("rst");

        // Case 1: single word, good checksum, back-to-back.
        send_byte(8'h01, 0);
        send_word(32'h20080005, 0);
        send_byte(8'h2C, 0);
        chk("t1_nwr",   32'(wa0.size()), 32'd1);
        chk("t1_addr",  32'(wa0[0]),     32'd0);
        chk("t1_data",  wd0[0],          32'h20080005);
        chk("t1_done",  32'(done0),      32'd1);
        chk("t1_hold",  32'(hold0),      32'd0);
        chk("t1_err",   32'(err0),       32'd0);
        chk("t1_rdy",   32'(sif0.in_ready), 32'd0);

        // Case 2: two words with random gaps.
        do_reset("r2");
        send_byte(8'h02, 3);
        send_word(32'h11223344, 3);
        send_word(32'hA5A55A5A, 3);
        send_byte(8'h46, 3);
        chk("t2_nwr",   32'(wa0.size()),  32'd2);
        chk("t2_addr0", 32'(wa0[0]),      32'd0);
        chk("t2_data0", wd0[0],           32'h11223344);
        chk("t2_addr1", 32'(wa0[1]),      32'd1);
        chk("t2_data1", wd0[1],           32'hA5A55A5A);
        chk("t2_rdy_in_write", 32'(rdy_in_write), 32'd0);
        chk("t2_done",  32'(done0),       32'd1);
        chk("t2_hold",  32'(hold0),       32'd0);

        // Case 3: bad checksum.
        do_reset("r3");
        send_byte(8'h01, 0);
        send_word(32'h20080005, 0);
        send_byte(8'h2D, 0);
        chk("t3_nwr",   32'(wa0.size()), 32'd1);
        chk("t3_data",  wd0[0],          32'h20080005);
        chk("t3_err",   32'(err0),       32'd1);
        chk("t3_done",  32'(done0),      32'd0);
        chk("t3_hold",  32'(hold0),      32'd1);
        st_valid = 1'b1;
        st_data  = 8'h01;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t3_rdy", 32'(sif0.in_ready), 32'd0);
        end
        st_valid = 1'b0;
        chk("t3_nwr_after", 32'(wa0.size()), 32'd1);
        chk("t3_err_after", 32'(err0),       32'd1);

        // Case 4: zero and oversized headers; 64 is the largest legal count.
        do_reset("r4a");
        send_byte(8'h00, 0);
        chk("t4_zero_err",  32'(err0),   32'd1);
        chk("t4_zero_done", 32'(done0),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_zero_nwr",  32'(wa0.size()), 32'd0);
        do_reset("r4b");
        send_byte(8'h41, 0);
        chk("t4_65_err",    32'(err0),   32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_65_nwr",    32'(wa0.size()), 32'd0);
        do_reset("r4c");
        send_byte(8'h40, 0);
        chk("t4_64_err",    32'(err0),   32'd0);
        chk("t4_64_rdy",    32'(sif0.in_ready), 32'd1);

        // Case 5: reset in the middle of word 1, then a fresh full load.
        do_reset("r5a");
        send_byte(8'h02, 2);
        send_word(32'h11223344, 2);
        send_byte(8'hA5, 2);
        send_byte(8'hA5, 2);
        chk("t5_pre_nwr", 32'(wa0.size()), 32'd1);
        do_reset("t5_mid");
        send_byte(8'h02, 2);
        send_word(32'h11223344, 2);
        send_word(32'hA5A55A5A, 2);
        send_byte(8'h46, 2);
        chk("t5_nwr",   32'(wa0.size()), 32'd2);
        chk("t5_addr0", 32'(wa0[0]),     32'd0);
        chk("t5_addr1", 32'(wa0[1]),     32'd1);
        chk("t5_data1", wd0[1],          32'hA5A55A5A);
        chk("t5_done",  32'(done0),      32'd1);

        // Case 6: three words on the instance based at 62 -> 62, 63, 0.
        do_reset("r6");
        send_byte(8'h03, 1);
        send_word(32'h01020304, 1);
        send_word(32'h05060708, 1);
        send_word(32'h090A0B0C, 1);
        send_byte(8'h0F, 1);
        chk("t6_nwr",   32'(wa1.size()), 32'd3);
        chk("t6_addr0", 32'(wa1[0]),     32'd62);
        chk("t6_addr1", 32'(wa1[1]),     32'd63);
        chk("t6_addr2", 32'(wa1[2]),     32'd0);
        chk("t6_data2", wd0[2],          32'h090A0B0C);
        chk("t6_done",  32'(done1),      32'd1);
        chk("t6_err",   32'(err1),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
